// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - start/instruction inputs and datapath control outputs of the control sequencer
interface control_sequencer_if;
  logic        run;
  logic [15:0] ir_in;
  logic [3:0]  reg_wr_code;
  logic        reg_wr_en;
  logic [3:0]  reg_rd_code;
  logic        a_load;
  logic        g_load;
  logic        g_out;
  logic [1:0]  alu_op;
  logic        busy;
  logic        done;
  logic [7:0]  instr_count;

  modport master (
    output run, ir_in,
    input  reg_wr_code, reg_wr_en, reg_rd_code, a_load, g_load, g_out,
    input  alu_op, busy, done, instr_count
  );

  modport slave (
    input  run, ir_in,
    output reg_wr_code, reg_wr_en, reg_rd_code, a_load, g_load, g_out,
    output alu_op, busy, done, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - four-state Moore sequencer for MV/ADD/SUB/AND/NOP instructions
module control_sequencer (
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] ir_q;
  logic [7:0]  count_q;

  logic [3:0]  opcode;
  logic [3:0]  rx;
  logic [3:0]  ry;
  logic        is_alu;
  logic [1:0]  alu_sel;
  logic        done_c;

  assign opcode  = ir_q[15:12];
  assign rx      = ir_q[11:8];
  assign ry      = ir_q[7:4];
  assign is_alu  = (opcode == 4'd1) || (opcode == 4'd2) || (opcode == 4'd3);
  // Opcodes 1/2/3 map onto alu_op 00/01/10.
  assign alu_sel = opcode[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      if (done_c) begin
        count_q <= count_q + 8'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            ir_q    <= bus.ir_in;
            state_q <= S_T1;
          end
        end
        S_T1:    state_q <= is_alu ? S_T2 : S_IDLE;
        S_T2:    state_q <= S_T3;
        S_T3:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.reg_rd_code = '0;
    bus.reg_wr_code = '0;
    bus.reg_wr_en   = 1'b0;
    bus.a_load      = 1'b0;
    bus.g_load      = 1'b0;
    bus.g_out       = 1'b0;
    bus.alu_op      = 2'b00;
    done_c          = 1'b0;
    case (state_q)
      S_T1: begin
        if (opcode == 4'd0) begin
          bus.reg_rd_code = ry;
          bus.reg_wr_code = rx;
          bus.reg_wr_en   = 1'b1;
          done_c          = 1'b1;
        end else if (is_alu) begin
          bus.reg_rd_code = rx;
          bus.a_load      = 1'b1;
        end else begin
          done_c          = 1'b1;
        end
      end
      S_T2: begin
        bus.reg_rd_code = ry;
        bus.alu_op      = alu_sel;
        bus.g_load      = 1'b1;
      end
      S_T3: begin
        bus.g_out       = 1'b1;
        bus.reg_wr_code = rx;
        bus.reg_wr_en   = 1'b1;
        bus.alu_op      = alu_sel;
        done_c          = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done        = done_c;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.instr_count = count_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  input  1  Single system clock; all state updates on rising edge.
REQ-002 reset  input  1  Synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 run  input  1  Start request; sampled only in IDLE.
REQ-004 ir_in  input  16  Instruction word: [15:12] opcode, [11:8] rx, [7:4] ry, [3:0] unused.
REQ-005 reg_wr_code  output  4  Destination register index; drives the 4-to-16 write-enable decoder.
REQ-006 reg_wr_en  output  1  Qualifies reg_wr_code; decoder output is used only when high.
REQ-007 reg_rd_code  output  4  Source register index driven onto the datapath bus.
REQ-008 a_load  output  1  Load ALU operand register A from bus.
REQ-009 g_load  output  1  Load ALU result register G.
REQ-010 g_out  output  1  Drive G onto bus instead of the register file.
REQ-011 alu_op  output  2  00 add, 01 sub, 10 and, 11 unused.
REQ-012 busy  output  1  High in every state except IDLE.
REQ-013 done  output  1  One-cycle pulse in final step of each instruction.
REQ-014 instr_count  output  8  Count of completed instructions.

Function
REQ-015 States SHALL be IDLE, T1, T2, T3; state and an internal 16-bit IR are the only control storage besides instr_count.
REQ-016 In IDLE with run=1, the block SHALL capture ir_in into IR and enter T1 on the same edge; with run=0 it SHALL stay in IDLE with IR unchanged.
REQ-017 run SHALL be ignored in T1, T2, T3; ir_in changes outside the capture edge SHALL have no effect.
REQ-018 Outputs SHALL be combinational functions of state and IR only (Moore); in IDLE all strobes, reg_wr_en and done SHALL be 0, codes 0, alu_op 00.
REQ-019 Opcode 0 (MV): T1 SHALL drive reg_rd_code=ry, reg_wr_code=rx, reg_wr_en=1, done=1; next state IDLE.
REQ-020 Opcodes 1/2/3 (ADD/SUB/AND): T1 reg_rd_code=rx, a_load=1 -> T2; T2 reg_rd_code=ry, alu_op=00/01/10 respectively, g_load=1 -> T3; T3 g_out=1, reg_wr_code=rx, reg_wr_en=1, done=1 -> IDLE.
REQ-021 alu_op SHALL be held at the instruction's value in T2 and T3 and be 00 elsewhere.
REQ-022 Opcodes 4-15 (NOP): T1 SHALL assert done=1 only, with reg_wr_en=0; next state IDLE.
REQ-023 Latency: done SHALL be high exactly 1 cycle after the capture edge for MV/NOP and exactly 3 cycles after for ALU ops.
REQ-024 reg_wr_en SHALL be high for at most one cycle per instruction and never outside the done cycle.
REQ-025 rx=ry SHALL be legal and sequenced identically (no special case).
REQ-026 instr_count SHALL increment by 1 on every edge leaving a done state, wrapping 255 -> 0.
REQ-027 With run held high continuously, a new instruction SHALL be captured on the first IDLE edge after each done (one IDLE cycle between instructions).

Reset
REQ-028 reset=1 SHALL, on the next rising edge, force state IDLE, IR=0, instr_count=0, taking priority over run and any in-flight step.
REQ-029 Reset mid-instruction SHALL abort it: no reg_wr_en or done pulse for the aborted instruction and no instr_count increment.
REQ-030 From the first edge with reset=1 until capture of a new instruction, all outputs SHALL equal IDLE values (REQ-018), busy=0, instr_count=0.

Verification
REQ-031 MV: ir_in=0x0350, run pulse -> T1: reg_rd_code=5, reg_wr_code=3, reg_wr_en=1, done=1; instr_count 0->1.
REQ-032 SUB: ir_in=0x2120 -> T1 rd=1,a_load; T2 rd=2,alu_op=01,g_load; T3 g_out, wr=1, wr_en, done; exactly 3 busy cycles.
REQ-033 run held high, ir_in toggling mid-op -> executed instruction equals value at capture edge; one IDLE cycle between dones.
REQ-034 reset asserted in T2 of ADD -> IDLE next edge, no reg_wr_en/done, instr_count unchanged at 0.
REQ-035 Opcode 0xF -> done in T1 with reg_wr_en=0; 256 back-to-back NOPs -> instr_count wraps to 0.
REQ-036 run pulse while busy -> ignored; no extra instruction, instr_count increments once.
